// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential divider and the MAC-side datapath.
// Helpers operate on a fixed 32-bit container; callers sign-extend in and slice out.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

  localparam int unsigned HelperWidth = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic [HelperWidth-1:0] neg(input logic [HelperWidth-1:0] value);
    return ~value + HelperWidth'(1);
  endfunction

  // Most negative n-bit value maps to 2^(n-1), which fits the unsigned n-bit slice.
  function automatic logic [HelperWidth-1:0] mag(input logic signed [HelperWidth-1:0] value);
    return value[HelperWidth-1] ? neg(value) : value;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module seq_divider_div_step #(
  parameter int unsigned BBIT = 8
) (
  input  logic [BBIT:0]   partial,
  input  logic            in_bit,
  input  logic [BBIT-1:0] divisor_mag,
  output logic [BBIT:0]   partial_next,
  output logic            quo_bit
);

  logic [BBIT+1:0] shifted;
  logic [BBIT+1:0] dsr_ext;

  always_comb begin
    shifted      = {partial, in_bit};
    dsr_ext      = {2'b00, divisor_mag};
    quo_bit      = (shifted >= dsr_ext);
    // The result is always below |divisor|, so the top bit is zero and can be dropped.
    partial_next = (BBIT + 1)'(quo_bit ? (shifted - dsr_ext) : shifted);
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes, then sign correction.
// Matches truncate-toward-zero semantics; one quotient bit per cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned NBIT = 16,
  parameter int unsigned BBIT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic signed [NBIT-1:0] i_dividend,
  input  logic signed [BBIT-1:0] i_divisor,
  output logic                   o_busy,
  output logic                   o_valid,
  output logic signed [NBIT-1:0] o_quotient,
  output logic signed [BBIT-1:0] o_remainder,
  output logic                   o_divZero,
  output logic                   o_overflow
);

  localparam int unsigned     CntW     = clog2(NBIT) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(NBIT - 1);
  localparam logic [NBIT-1:0] MinDvd   = {1'b1, {(NBIT - 1){1'b0}}};

  div_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [NBIT-1:0] dvd_q;  // dividend magnitude, consumed MSB first
  logic [NBIT-1:0] quo_q;
  logic [BBIT-1:0] dsr_q;
  logic [BBIT:0]   part_q;
  logic            neg_dvd_q;
  logic            neg_dsr_q;
  logic            div_zero_q;
  logic            ovf_q;
  logic            done_q;

  logic [BBIT:0]   part_next;
  logic            quo_bit;
  logic            accept;
  logic [NBIT-1:0] quo_final;
  logic [BBIT-1:0] rem_final;

  seq_divider_div_step #(
    .BBIT(BBIT)
  ) u_div_step (
    .partial     (part_q),
    .in_bit      (dvd_q[NBIT-1]),
    .divisor_mag (dsr_q),
    .partial_next(part_next),
    .quo_bit     (quo_bit)
  );

  // o_busy lags the state by a cycle, so the DONE->IDLE cycle must still refuse starts.
  assign accept = i_start && (state_q == StIdle) && !o_busy;

  always_comb begin
    quo_final = quo_q;
    rem_final = BBIT'(part_q);
    if (neg_dvd_q ^ neg_dsr_q) quo_final = NBIT'(neg(HelperWidth'(quo_q)));
    if (neg_dvd_q) rem_final = BBIT'(neg(HelperWidth'(rem_final)));
    if (div_zero_q) begin
      quo_final = '1;
      rem_final = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      part_q      <= '0;
      neg_dvd_q   <= 1'b0;
      neg_dsr_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      o_busy      <= 1'b0;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_divZero   <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_busy  <= (state_q != StIdle);
      o_valid <= 1'b0;
      done_q  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dvd_q      <= NBIT'(mag(HelperWidth'(i_dividend)));
            dsr_q      <= BBIT'(mag(HelperWidth'(i_divisor)));
            neg_dvd_q  <= i_dividend[NBIT-1];
            neg_dsr_q  <= i_divisor[BBIT-1];
            div_zero_q <= (i_divisor == '0);
            ovf_q      <= (i_dividend == MinDvd) && (i_divisor == '1);
            part_q     <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          part_q <= part_next;
          dvd_q  <= {dvd_q[NBIT-2:0], 1'b0};
          quo_q  <= {quo_q[NBIT-2:0], quo_bit};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastIter) state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Results publish one cycle after DONE so they line up with o_busy falling.
      if (done_q) begin
        o_quotient  <= quo_final;
        o_remainder <= rem_final;
        o_divZero   <= div_zero_q;
        o_overflow  <= ovf_q;
        o_valid     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (NBIT=16, BBIT=8) using an expected-result queue.
module tb_seq_divider;

  localparam int unsigned NBIT = 16;
  localparam int unsigned BBIT = 8;
  localparam int          Budget = 40;

  typedef struct packed {
    logic [NBIT-1:0] q;
    logic [BBIT-1:0] r;
    logic            dz;
    logic            ovf;
  } res_t;

  logic                   i_clk;
  logic                   i_rst;
  logic                   i_start;
  logic signed [NBIT-1:0] i_dividend;
  logic signed [BBIT-1:0] i_divisor;
  logic                   o_busy;
  logic                   o_valid;
  logic signed [NBIT-1:0] o_quotient;
  logic signed [BBIT-1:0] o_remainder;
  logic                   o_divZero;
  logic                   o_overflow;

  int   checks;
  int   failures;
  res_t exp_q[$];

  seq_divider #(
    .NBIT(NBIT),
    .BBIT(BBIT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder),
    .o_divZero  (o_divZero),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic res_t model(input logic signed [NBIT-1:0] a, input logic signed [BBIT-1:0] b);
    res_t e;
    int   ai;
    int   bi;
    int   qi;
    int   ri;
    ai = a;
    bi = b;
    if (bi == 0) begin
      e.q   = '1;
      e.r   = '0;
      e.dz  = 1'b1;
      e.ovf = 1'b0;
    end else begin
      qi    = ai / bi;
      ri    = ai % bi;
      e.q   = qi[NBIT-1:0];
      e.r   = ri[BBIT-1:0];
      e.dz  = 1'b0;
      e.ovf = (ai == -32768) && (bi == -1);
    end
    return e;
  endfunction

  function automatic res_t observed();
    res_t o;
    o = {o_quotient, o_remainder, o_divZero, o_overflow};
    return o;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_op(input logic signed [NBIT-1:0] a, input logic signed [BBIT-1:0] b);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    exp_q.push_back(model(a, b));
  endtask

  // Returns cycles from the start edge until o_valid, and cycles o_busy was seen high.
  task automatic wait_valid(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!o_valid && lat < Budget) begin
      tick();
      lat++;
      if (o_busy) busy_cnt++;
    end
    if (!o_valid) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: o_valid not seen after %0d cycles, required within %0d",
               lat, Budget);
    end
  endtask

  task automatic pop_exp(output res_t e);
    if (exp_q.size() == 0) begin
      e = '0;
      failures++;
      checks++;
      $display("FAIL scoreboard_empty: result seen with no expected entry queued");
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_busy, o_valid, o_quotient, o_remainder, o_divZero, o_overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b valid=%b q=%h r=%h dz=%b ovf=%b required all 0",
               o_busy, o_valid, o_quotient, o_remainder, o_divZero, o_overflow);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int   lat;
    int   bc;
    res_t e;
    start_op(16'sd1000, 8'sd7);
    wait_valid(lat, bc);
    pop_exp(e);
    checks++;
    if (lat != 18) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles required 18", lat);
    end
    checks++;
    if (bc != 17) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d required 17", bc);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_in_valid: got %b required 0", o_busy);
    end
    checks++;
    if (observed() !== e || o_quotient !== 16'sd142 || o_remainder !== 8'sd6) begin
      failures++;
      $display("FAIL basic_result: got %h required %h (q=142 r=6)", observed(), e);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse_width: o_valid got %b required 0", o_valid);
    end
  endtask

  task automatic test_signs();
    logic signed [NBIT-1:0] a[5] = '{-16'sd1000, 16'sd1000, -16'sd1000, -16'sd5, 16'sd0};
    logic signed [BBIT-1:0] b[5] = '{8'sd7, -8'sd7, -8'sd7, -8'sd128, -8'sd3};
    int   lat;
    int   bc;
    res_t e;
    for (int i = 0; i < 5; i++) begin
      start_op(a[i], b[i]);
      wait_valid(lat, bc);
      pop_exp(e);
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL signs_%0d: %0d/%0d got %h required %h", i, a[i], b[i], observed(), e);
      end
    end
  endtask

  task automatic test_div_zero();
    int   lat;
    int   bc;
    res_t e;
    start_op(16'sd5, 8'sd0);
    wait_valid(lat, bc);
    pop_exp(e);
    checks++;
    if (lat != 18) begin
      failures++;
      $display("FAIL divzero_latency: got %0d required 18", lat);
    end
    checks++;
    if (observed() !== e || o_divZero !== 1'b1) begin
      failures++;
      $display("FAIL divzero_result: got %h required %h", observed(), e);
    end
    start_op(16'sd9, 8'sd3);
    wait_valid(lat, bc);
    pop_exp(e);
    checks++;
    if (observed() !== e || o_divZero !== 1'b0) begin
      failures++;
      $display("FAIL divzero_clear: got %h required %h", observed(), e);
    end
  endtask

  task automatic test_extremes();
    logic signed [NBIT-1:0] a[3] = '{-16'sd32768, -16'sd32768, 16'sd32767};
    logic signed [BBIT-1:0] b[3] = '{-8'sd1, -8'sd128, 8'sd127};
    int   lat;
    int   bc;
    res_t e;
    for (int i = 0; i < 3; i++) begin
      start_op(a[i], b[i]);
      wait_valid(lat, bc);
      pop_exp(e);
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL extreme_%0d: %0d/%0d got %h required %h", i, a[i], b[i], observed(), e);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int   lat;
    int   bc;
    int   extra;
    res_t e;
    start_op(16'sd1000, 8'sd7);
    repeat (5) tick();
    i_dividend = 16'sd50;
    i_divisor  = 8'sd3;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    wait_valid(lat, bc);
    pop_exp(e);
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL ignore_busy_result: got %h required %h", observed(), e);
    end
    extra = 0;
    repeat (25) begin
      tick();
      if (o_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_busy_queued: got %0d extra valid pulses required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    int   bc;
    res_t e;
    start_op(16'sd1234, 8'sd11);
    wait_valid(lat, bc);
    pop_exp(e);
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL b2b_first: got %h required %h", observed(), e);
    end
    start_op(-16'sd2000, 8'sd13);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pulse: o_valid got %b required 0", o_valid);
    end
    wait_valid(lat, bc);
    pop_exp(e);
    checks++;
    if (lat != 18) begin
      failures++;
      $display("FAIL b2b_latency: got %0d required 18", lat);
    end
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL b2b_second: got %h required %h", observed(), e);
    end
  endtask

  task automatic test_reset_abort();
    int   lat;
    int   bc;
    int   extra;
    res_t e;
    i_dividend = 16'sd1000;
    i_divisor  = 8'sd7;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (5) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checks++;
    if ({o_busy, o_valid, o_quotient, o_remainder, o_divZero, o_overflow} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: got busy=%b valid=%b q=%h r=%h dz=%b ovf=%b required all 0",
               o_busy, o_valid, o_quotient, o_remainder, o_divZero, o_overflow);
    end
    extra = 0;
    repeat (25) begin
      tick();
      if (o_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL abort_valid: got %0d valid pulses required 0", extra);
    end
    start_op(16'sd100, 8'sd9);
    wait_valid(lat, bc);
    pop_exp(e);
    checks++;
    if (observed() !== e || o_quotient !== 16'sd11 || o_remainder !== 8'sd1) begin
      failures++;
      $display("FAIL abort_recover: got %h required %h (q=11 r=1)", observed(), e);
    end
  endtask

  task automatic test_random();
    logic signed [NBIT-1:0] a;
    logic signed [BBIT-1:0] b;
    int   lat;
    int   bc;
    res_t e;
    for (int i = 0; i < 20; i++) begin
      a = NBIT'($urandom);
      b = BBIT'($urandom_range(0, 255));
      start_op(a, b);
      wait_valid(lat, bc);
      pop_exp(e);
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL random_%0d: %0d/%0d got %h required %h", i, a, b, observed(), e);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_extremes();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
